rf_sequencer: RTL and testbench

Multi-cycle command sequencer and two-port arbiter for the 8-bit register file (R1–R4, T1–T4; FunSel 00 clear / 01 load / 10 decrement / 11 increment). Two requesters submit micro-commands over valid/ready. The block grants them round-robin and drives the register file's select, enable and function lines. It runs repeated increments/decrements, register-to-register moves and readbacks. It is the only driver of the register-file control inputs.

---
 rtl/rf_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_rf_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: two-requester round-robin arbiter and multi-cycle command
// sequencer that is the sole driver of the 8-bit register file controls.
// Register codes follow the O1Sel encoding: 000..011 = T1..T4, 100..111 = R1..R4.
module rf_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [5:0]           req_op,
    input  logic [5:0]           req_dst,
    input  logic [5:0]           req_src,
    input  logic [15:0]          req_imm,
    input  logic [2*CNT_W-1:0]   req_cnt,
    output logic [1:0]           done,
    output logic [7:0]           rd_data,
    output logic [2:0]           rf_o1_sel,
    output logic [2:0]           rf_o2_sel,
    output logic [1:0]           rf_fun_sel,
    output logic [3:0]           rf_rsel,
    output logic [3:0]           rf_tsel,
    output logic [7:0]           rf_i,
    input  logic [7:0]           rf_o1
);

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_CLR    = 3'd0;
    localparam logic [2:0] OP_LDI    = 3'd1;
    localparam logic [2:0] OP_INC    = 3'd2;
    localparam logic [2:0] OP_DEC    = 3'd3;
    localparam logic [2:0] OP_MOV    = 3'd4;
    localparam logic [2:0] OP_RD     = 3'd5;
    localparam logic [2:0] OP_CLRALL = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MOV_RD,
        S_MOV_WR,
        S_RD,
        S_DONE
    } state_t;

    // Register-file control bundle, held in flops so every output is registered
    typedef struct packed {
        logic [3:0]        rsel;
        logic [3:0]        tsel;
        logic [1:0]        fun;
        logic [DATA_W-1:0] din;
        logic [2:0]        o1;
        logic [2:0]        o2;
        logic [1:0]        dn;
    } rf_ctl_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [2:0]        dst_q;
    logic [2:0]        src_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gnt_q;
    logic              last_gnt;
    rf_ctl_t           ctl_q;

    logic              gnt_sel;
    logic              accept;
    logic [2:0]        op_in;
    logic [2:0]        dst_in;
    logic [2:0]        src_in;
    logic [DATA_W-1:0] imm_in;
    logic [CNT_W-1:0]  cnt_in;
    logic [CNT_W-1:0]  cnt_load;

    // First state after accepting a command of the given op
    function automatic state_t entry_state(input logic [2:0] op);
        state_t st;
        case (op)
            OP_MOV:  st = S_MOV_RD;
            OP_RD:   st = S_RD;
            3'd7:    st = S_DONE;
            default: st = S_EXEC;
        endcase
        return st;
    endfunction

    // Register-file controls to present while in state st for the given command
    function automatic rf_ctl_t decode(input state_t            st,
                                       input logic [2:0]        op,
                                       input logic [2:0]        dst,
                                       input logic [2:0]        src,
                                       input logic [DATA_W-1:0] imm,
                                       input logic [DATA_W-1:0] hold,
                                       input logic              gnt);
        rf_ctl_t    c;
        logic [3:0] oh;
        c  = '0;
        oh = 4'b1000 >> dst[1:0];
        case (st)
            S_EXEC: begin
                if (op == OP_CLRALL) begin
                    c.rsel = 4'b1111;
                    c.tsel = 4'b1111;
                end else if (dst[2]) begin
                    c.rsel = oh;
                end else begin
                    c.tsel = oh;
                end
                case (op)
                    OP_LDI: begin
                        c.fun = 2'b01;
                        c.din = imm;
                    end
                    OP_INC:  c.fun = 2'b11;
                    OP_DEC:  c.fun = 2'b10;
                    default: c.fun = 2'b00;
                endcase
            end
            S_MOV_RD: c.o1 = src;
            S_MOV_WR: begin
                if (dst[2]) c.rsel = oh;
                else        c.tsel = oh;
                c.fun = 2'b01;
                c.din = hold;
            end
            S_RD:    c.o1 = dst;
            S_DONE:  c.dn = gnt ? 2'b10 : 2'b01;
            default: c = '0;
        endcase
        if (st != S_IDLE) c.o2 = dst;
        return c;
    endfunction

    // Round-robin pick: a lone requester wins, with both valid the one not granted last wins
    always_comb begin
        gnt_sel = req_valid[1];
        if (req_valid == 2'b11) gnt_sel = ~last_gnt;
    end

    assign accept    = rst_n && (state == S_IDLE) && (req_valid != 2'b00);
    assign req_ready = {accept && gnt_sel, accept && !gnt_sel};

    assign op_in    = gnt_sel ? req_op[5:3]  : req_op[2:0];
    assign dst_in   = gnt_sel ? req_dst[5:3] : req_dst[2:0];
    assign src_in   = gnt_sel ? req_src[5:3] : req_src[2:0];
    assign imm_in   = gnt_sel ? req_imm[15:8] : req_imm[7:0];
    assign cnt_in   = gnt_sel ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
    // A zero repeat count still performs one step; other ops run a single EXEC cycle
    assign cnt_load = ((op_in == OP_INC) || (op_in == OP_DEC)) && (cnt_in != '0) ? cnt_in : CNT_W'(1);

    // Sequencer FSM: accepts, latches the command and registers the next cycle's controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            rd_data  <= '0;
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            ctl_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op_in;
                        dst_q    <= dst_in;
                        src_q    <= src_in;
                        imm_q    <= imm_in;
                        cnt_q    <= cnt_load;
                        gnt_q    <= gnt_sel;
                        last_gnt <= gnt_sel;
                        state    <= entry_state(op_in);
                        ctl_q    <= decode(entry_state(op_in), op_in, dst_in, src_in,
                                           imm_in, hold_q, gnt_sel);
                    end
                end
                S_EXEC: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        state <= S_DONE;
                        ctl_q <= decode(S_DONE, op_q, dst_q, src_q, imm_q, hold_q, gnt_q);
                    end
                end
                S_MOV_RD: begin
                    hold_q <= rf_o1;
                    state  <= S_MOV_WR;
                    ctl_q  <= decode(S_MOV_WR, op_q, dst_q, src_q, imm_q, rf_o1, gnt_q);
                end
                S_MOV_WR: begin
                    state <= S_DONE;
                    ctl_q <= decode(S_DONE, op_q, dst_q, src_q, imm_q, hold_q, gnt_q);
                end
                S_RD: begin
                    rd_data <= rf_o1;
                    state   <= S_DONE;
                    ctl_q   <= decode(S_DONE, op_q, dst_q, src_q, imm_q, hold_q, gnt_q);
                end
                default: begin
                    state <= S_IDLE;
                    ctl_q <= '0;
                end
            endcase
        end
    end

    // Enables are gated by rst_n so no register-file write can land during reset
    assign rf_rsel    = rst_n ? ctl_q.rsel : 4'b0000;
    assign rf_tsel    = rst_n ? ctl_q.tsel : 4'b0000;
    assign rf_fun_sel = ctl_q.fun;
    assign rf_i       = ctl_q.din;
    assign rf_o1_sel  = ctl_q.o1;
    assign rf_o2_sel  = ctl_q.o2;
    assign done       = ctl_q.dn;

endmodule

// File: tb/tb_rf_sequencer.sv
// Testbench for rf_sequencer: behavioural register file as environment, a
// command-level reference model, a vector table, corner sequences and random commands.
module tb_rf_sequencer;

    localparam int CNT_W = 4;

    localparam logic [2:0] OP_CLR = 3'd0, OP_LDI = 3'd1, OP_INC = 3'd2, OP_DEC = 3'd3;
    localparam logic [2:0] OP_MOV = 3'd4, OP_RD = 3'd5, OP_CLRALL = 3'd6, OP_NOP = 3'd7;
    localparam logic [2:0] T1 = 3'd0, T2 = 3'd1, T3 = 3'd2, T4 = 3'd3;
    localparam logic [2:0] R1 = 3'd4, R2 = 3'd5, R3 = 3'd6, R4 = 3'd7;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [5:0]           req_op;
    logic [5:0]           req_dst;
    logic [5:0]           req_src;
    logic [15:0]          req_imm;
    logic [2*CNT_W-1:0]   req_cnt;
    logic [1:0]           done;
    logic [7:0]           rd_data;
    logic [2:0]           rf_o1_sel;
    logic [2:0]           rf_o2_sel;
    logic [1:0]           rf_fun_sel;
    logic [3:0]           rf_rsel;
    logic [3:0]           rf_tsel;
    logic [7:0]           rf_i;
    logic [7:0]           rf_o1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rf_regs  [8];
    logic [7:0] ref_regs [8];
    logic [7:0] en_by_code;

    rf_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_dst    (req_dst),
        .req_src    (req_src),
        .req_imm    (req_imm),
        .req_cnt    (req_cnt),
        .done       (done),
        .rd_data    (rd_data),
        .rf_o1_sel  (rf_o1_sel),
        .rf_o2_sel  (rf_o2_sel),
        .rf_fun_sel (rf_fun_sel),
        .rf_rsel    (rf_rsel),
        .rf_tsel    (rf_tsel),
        .rf_i       (rf_i),
        .rf_o1      (rf_o1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: enable per register code, FunSel 00 clr / 01 load / 10 dec / 11 inc
    assign en_by_code = {rf_rsel[0], rf_rsel[1], rf_rsel[2], rf_rsel[3],
                         rf_tsel[0], rf_tsel[1], rf_tsel[2], rf_tsel[3]};
    assign rf_o1 = rf_regs[rf_o1_sel];

    always @(posedge clk) begin
        for (int c = 0; c < 8; c++) begin
            if (en_by_code[c[2:0]]) begin
                case (rf_fun_sel)
                    2'b00: rf_regs[c[2:0]] <= 8'h00;
                    2'b01: rf_regs[c[2:0]] <= rf_i;
                    2'b10: rf_regs[c[2:0]] <= rf_regs[c[2:0]] - 8'h01;
                    default: rf_regs[c[2:0]] <= rf_regs[c[2:0]] + 8'h01;
                endcase
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack_rf();
        logic [63:0] p;
        for (int k = 0; k < 8; k++) p[8*k +: 8] = rf_regs[k];
        return p;
    endfunction

    function automatic logic [63:0] pack_ref();
        logic [63:0] p;
        for (int k = 0; k < 8; k++) p[8*k +: 8] = ref_regs[k];
        return p;
    endfunction

    // Command-level reference: register effect, cycles from accept to done, RD value
    task automatic model(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic [3:0] cnt,
                         output int lat, output logic [7:0] rd);
        int n;
        n   = (cnt == 4'd0) ? 1 : int'(cnt);
        rd  = 8'h00;
        lat = 2;
        case (op)
            OP_CLR: ref_regs[dst] = 8'h00;
            OP_LDI: ref_regs[dst] = imm;
            OP_INC: begin ref_regs[dst] = ref_regs[dst] + 8'(n); lat = n + 1; end
            OP_DEC: begin ref_regs[dst] = ref_regs[dst] - 8'(n); lat = n + 1; end
            OP_MOV: begin ref_regs[dst] = ref_regs[src]; lat = 3; end
            OP_RD:  rd = ref_regs[dst];
            OP_CLRALL: for (int k = 0; k < 8; k++) ref_regs[k] = 8'h00;
            default: lat = 1;
        endcase
    endtask

    task automatic drive(input int g, input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [7:0] imm, input logic [3:0] cnt);
        req_op[3*g +: 3]  = op;
        req_dst[3*g +: 3] = dst;
        req_src[3*g +: 3] = src;
        req_imm[8*g +: 8] = imm;
        req_cnt[4*g +: 4] = cnt;
        req_valid[g]      = 1'b1;
    endtask

    task automatic wait_ready(input int g, output bit ok);
        int w;
        w = 0;
        #1;
        while (req_ready[g] !== 1'b1 && w < 60) begin
            @(negedge clk);
            #1;
            w++;
        end
        ok = (req_ready[g] === 1'b1);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout req%0d ready=%b required=1", g, req_ready[g]);
        end
    endtask

    // Issue one command and return cycles from accept to its done pulse (-1 if none)
    task automatic send(input int g, input logic [2:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic [7:0] imm, input logic [3:0] cnt,
                        output int lat);
        bit ok;
        bit seen;
        int acc;
        lat = -1;
        @(negedge clk);
        drive(g, op, dst, src, imm, cnt);
        wait_ready(g, ok);
        if (ok) begin
            acc = cyc;
            @(posedge clk);
            #1;
            req_valid[g] = 1'b0;
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                if (done[g] === 1'b1) begin
                    seen = 1'b1;
                    lat  = cyc - acc;
                end
            end
        end else begin
            req_valid[g] = 1'b0;
        end
    endtask

    typedef struct {
        int         g;
        logic [2:0] op;
        logic [2:0] dst;
        logic [2:0] src;
        logic [7:0] imm;
        logic [3:0] cnt;
        int         exp_lat;
        bit         chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int         lat;
        int         mlat;
        logic [7:0] mrd;
        int         grants [6];
        int         ng;
        bit         both;
        bit         ok;
        int         acc;
        bit         seen_done;
        bit         seen_rdy1;
        bit         seen_done1;
        int         done0_cyc;

        for (int k = 0; k < 8; k++) begin
            rf_regs[k]  = 8'h00;
            ref_regs[k] = 8'h00;
        end
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_dst   = '0;
        req_src   = '0;
        req_imm   = '0;
        req_cnt   = '0;

        // Reset with both requesters already asking: nothing may be accepted
        drive(0, OP_CLR, T1, T1, 8'h00, 4'd0);
        drive(1, OP_CLR, T2, T2, 8'h00, 4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_enables", {rf_rsel, rf_tsel}, 8'h00);
        chk("rst_fun_i", {rf_fun_sel, rf_i}, 10'h000);
        chk("rst_sel", {rf_o1_sel, rf_o2_sel}, 6'o00);

        // Arbitration: both held valid from the first cycle after reset
        for (int k = 0; k < 6; k++) grants[k] = -1;
        ng   = 0;
        both = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 40 && ng < 6; k++) begin
            #1;
            if (req_ready == 2'b11) both = 1'b1;
            if (req_ready == 2'b01) begin grants[ng] = 0; ng++; end
            else if (req_ready == 2'b10) begin grants[ng] = 1; ng++; end
            @(negedge clk);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 6; k++) chk($sformatf("arb_grant%0d", k), grants[k], k % 2);
        chk("arb_single_ready", both, 1'b0);
        repeat (4) @(negedge clk);
        chk("arb_regs", pack_rf(), pack_ref());

        // Vector table: {requester, op, dst, src, imm, cnt, latency, check rd, rd value}
        vecs.push_back('{0, OP_LDI, R1, T1, 8'h14, 4'd0, 2, 1'b0, 8'h00});
        vecs.push_back('{0, OP_INC, R1, T1, 8'h00, 4'd3, 4, 1'b0, 8'h00});
        vecs.push_back('{0, OP_RD,  R1, T1, 8'h00, 4'd0, 2, 1'b1, 8'h17});
        vecs.push_back('{1, OP_LDI, T4, T1, 8'hA5, 4'd0, 2, 1'b0, 8'h00});
        vecs.push_back('{1, OP_MOV, R3, T4, 8'h00, 4'd0, 3, 1'b0, 8'h00});
        vecs.push_back('{0, OP_RD,  R3, T1, 8'h00, 4'd0, 2, 1'b1, 8'hA5});
        vecs.push_back('{0, OP_MOV, R3, R3, 8'h00, 4'd0, 3, 1'b0, 8'h00});
        vecs.push_back('{1, OP_RD,  R3, T1, 8'h00, 4'd0, 2, 1'b1, 8'hA5});
        vecs.push_back('{0, OP_LDI, R2, T1, 8'h00, 4'd0, 2, 1'b0, 8'h00});
        vecs.push_back('{0, OP_DEC, R2, T1, 8'h00, 4'd0, 2, 1'b0, 8'h00});
        vecs.push_back('{1, OP_RD,  R2, T1, 8'h00, 4'd0, 2, 1'b1, 8'hFF});
        vecs.push_back('{0, OP_LDI, R4, T1, 8'hFF, 4'd0, 2, 1'b0, 8'h00});
        vecs.push_back('{1, OP_INC, R4, T1, 8'h00, 4'd1, 2, 1'b0, 8'h00});
        vecs.push_back('{0, OP_RD,  R4, T1, 8'h00, 4'd0, 2, 1'b1, 8'h00});
        vecs.push_back('{1, OP_INC, T3, T1, 8'h00, 4'd15, 16, 1'b0, 8'h00});
        vecs.push_back('{0, OP_RD,  T3, T1, 8'h00, 4'd0, 2, 1'b1, 8'h0F});
        vecs.push_back('{1, OP_CLRALL, R1, T1, 8'h00, 4'd5, 2, 1'b0, 8'h00});
        for (int k = 0; k < 8; k++)
            vecs.push_back('{k % 2, OP_RD, 3'(k), T1, 8'h00, 4'd0, 2, 1'b1, 8'h00});
        vecs.push_back('{1, OP_NOP, R1, T1, 8'h00, 4'd0, 1, 1'b0, 8'h00});

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].g, vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].imm, vecs[i].cnt, lat);
            model(vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].imm, vecs[i].cnt, mlat, mrd);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_regs", i), pack_rf(), pack_ref());
        end

        // MOV cycle-by-cycle: read phase, then write phase with R3 enable and loaded data
        send(0, OP_LDI, T4, T1, 8'hA5, 4'd0, lat);
        model(OP_LDI, T4, T1, 8'hA5, 4'd0, mlat, mrd);
        @(negedge clk);
        drive(0, OP_MOV, R3, T4, 8'h00, 4'd0);
        wait_ready(0, ok);
        if (ok) begin
            acc = cyc;
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            @(negedge clk);
            chk("movrd_o1_sel", rf_o1_sel, T4);
            chk("movrd_enables", {rf_rsel, rf_tsel}, 8'h00);
            @(negedge clk);
            chk("movwr_rsel_tsel", {rf_rsel, rf_tsel}, 8'b0010_0000);
            chk("movwr_fun", rf_fun_sel, 2'b01);
            chk("movwr_rf_i", rf_i, 8'hA5);
            chk("movwr_o2_sel", rf_o2_sel, R3);
            @(negedge clk);
            chk("mov_done", done, 2'b01);
            chk("mov_done_latency", cyc - acc, 3);
        end
        req_valid[0] = 1'b0;
        model(OP_MOV, R3, T4, 8'h00, 4'd0, mlat, mrd);
        @(negedge clk);
        chk("mov_regs", pack_rf(), pack_ref());

        // Reset mid-command: INC R4 x15 from 0, reset after five EXEC cycles
        send(1, OP_CLR, R4, T1, 8'h00, 4'd0, lat);
        model(OP_CLR, R4, T1, 8'h00, 4'd0, mlat, mrd);
        seen_done = 1'b0;
        @(negedge clk);
        drive(0, OP_INC, R4, T1, 8'h00, 4'd15);
        wait_ready(0, ok);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 2'b00) seen_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_enables", {rf_rsel, rf_tsel}, 8'h00);
        @(negedge clk);
        chk("midrst_state_outputs", {rf_fun_sel, rf_i, rf_o1_sel, rf_o2_sel, done}, 18'h0);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done !== 2'b00) seen_done = 1'b1;
        end
        chk("midrst_no_done", seen_done, 1'b0);
        chk("midrst_r4", rf_regs[R4], 8'h05);
        ref_regs[R4] = 8'h05;
        send(1, OP_RD, R4, T1, 8'h00, 4'd0, lat);
        model(OP_RD, R4, T1, 8'h00, 4'd0, mlat, mrd);
        chk("midrst_rd_latency", lat, 2);
        chk("midrst_rd_data", rd_data, 8'h05);

        // Handshake withdrawal: req1 valid for one busy cycle only
        @(negedge clk);
        drive(0, OP_INC, T1, T1, 8'h00, 4'd8);
        wait_ready(0, ok);
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        seen_rdy1  = 1'b0;
        seen_done1 = 1'b0;
        done0_cyc  = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) drive(1, OP_RD, T1, T1, 8'h00, 4'd0);
            else        req_valid[1] = 1'b0;
            #1;
            if (req_ready[1] !== 1'b0) seen_rdy1 = 1'b1;
            if (done[1] !== 1'b0) seen_done1 = 1'b1;
            if (done[0] === 1'b1) done0_cyc = cyc;
        end
        model(OP_INC, T1, T1, 8'h00, 4'd8, mlat, mrd);
        chk("withdraw_no_ready1", seen_rdy1, 1'b0);
        chk("withdraw_no_done1", seen_done1, 1'b0);
        chk("withdraw_done0_latency", done0_cyc - acc, mlat);
        chk("withdraw_regs", pack_rf(), pack_ref());

        // Random commands against the reference model
        for (int i = 0; i < 80; i++) begin
            int         g;
            logic [2:0] op;
            logic [2:0] dst;
            logic [2:0] src;
            logic [7:0] imm;
            logic [3:0] cnt;
            g   = int'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            src = 3'($urandom_range(0, 7));
            imm = 8'($urandom_range(0, 255));
            cnt = 4'($urandom_range(0, 15));
            send(g, op, dst, src, imm, cnt, lat);
            model(op, dst, src, imm, cnt, mlat, mrd);
            chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, mlat);
            if (op == OP_RD) chk($sformatf("rnd%0d_rd_data", i), rd_data, mrd);
            chk($sformatf("rnd%0d_regs", i), pack_rf(), pack_ref());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
